// File: rtl/itcm_arb_if.sv
// itcm_arb_if: IFU/LSU request-response channels plus the ITCM RAM port around the arbiter
//   slave  : arbiter side (takes requests and ram_dout, drives readies, responses and RAM controls)
//   master : environment side (requesters and RAM model)
interface itcm_arb_if #(parameter int AW = 14, DW = 32, MW = 4);
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_rsp_rdata;
  logic [MW-1:0] lsu_req_wem;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [MW-1:0] ram_wem;
  modport slave (
    input  ifu_req_valid, ifu_req_addr, lsu_req_valid, lsu_req_addr, lsu_req_we,
           lsu_req_wdata, lsu_req_wem, ram_dout,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, lsu_req_ready, lsu_rsp_valid,
           lsu_rsp_rdata, ram_we, ram_addr, ram_din, ram_wem
  );
  modport master (
    output ifu_req_valid, ifu_req_addr, lsu_req_valid, lsu_req_addr, lsu_req_we,
           lsu_req_wdata, lsu_req_wem, ram_dout,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, lsu_req_ready, lsu_rsp_valid,
           lsu_rsp_rdata, ram_we, ram_addr, ram_din, ram_wem
  );
endinterface

// File: rtl/itcm_arb_ctrl.sv
// itcm_arb_ctrl: LSU-priority arbiter with IFU starvation guard in front of a single-port ITCM RAM
//   clk, rst : clock and asynchronous active-high reset
//   bus      : itcm_arb_if.slave carrying IFU/LSU request-response channels and RAM port
module itcm_arb_ctrl #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  itcm_arb_if.slave bus
);
  typedef enum logic [1:0] {NONE, IFU, LSU} owner_t;
  owner_t owner, owner_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic [AW-1:0] held_addr;
  logic gi, gl, lw;
  always_comb begin
    gl = bus.lsu_req_valid && !rst && !(bus.ifu_req_valid && starve_cnt == 4'(STARVE_MAX));
    gi = bus.ifu_req_valid && !rst && !gl;
    lw = gl && bus.lsu_req_we;
    owner_nxt = gl ? LSU : gi ? IFU : NONE;
    starve_nxt = (!bus.ifu_req_valid || gi) ? 4'd0
               : (gl && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= NONE;
      starve_cnt <= '0;
      held_addr <= '0;
    end else begin
      owner <= owner_nxt;
      starve_cnt <= starve_nxt;
      held_addr <= bus.ram_addr;
    end
  end
  assign bus.ifu_req_ready = gi;
  assign bus.lsu_req_ready = gl;
  // Without a grant the address register keeps the RAM pointed at the last access so ram_dout stays stable.
  assign bus.ram_addr = gl ? bus.lsu_req_addr : gi ? bus.ifu_req_addr : held_addr;
  assign bus.ram_we = lw;
  assign bus.ram_din = lw ? bus.lsu_req_wdata : '0;
  assign bus.ram_wem = lw ? bus.lsu_req_wem : '0;
  assign bus.ifu_rsp_valid = owner == IFU;
  assign bus.lsu_rsp_valid = owner == LSU;
  assign bus.ifu_rsp_rdata = bus.ram_dout;
  assign bus.lsu_rsp_rdata = bus.ram_dout;
endmodule

// File: tb/tb_itcm_arb_ctrl.sv
// tb_itcm_arb_ctrl: vector table, corner sequences and randomized traffic against a transaction-level model
module tb_itcm_arb_ctrl;
  localparam int AW = 14, DW = 32, MW = 4, SM = 4;
  logic clk = 0, rst = 1, mem_clr = 0;
  always #5 clk = ~clk;
  itcm_arb_if #(.AW(AW), .DW(DW), .MW(MW)) bus ();
  itcm_arb_ctrl #(.AW(AW), .DW(DW), .MW(MW), .STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int checks = 0, errors = 0;
  function automatic logic [31:0] init_word(int a);
    case (a)
      16: return 32'hA0;
      17: return 32'hA1;
      18: return 32'hA2;
      32: return 32'h1122_3344;
      default: return 32'h5A00_0000 | (a * 32'h0001_0103);
    endcase
  endfunction
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    else if (bus.ram_we)
      for (int b = 0; b < 4; b++) if (bus.ram_wem[b]) mem[bus.ram_addr[7:0]][8*b+:8] <= bus.ram_din[8*b+:8];
    bus.ram_dout <= mem[bus.ram_addr[7:0]];
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic apply_wr(logic [13:0] a, logic [31:0] d, logic [3:0] m);
    for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a[7:0]][8*b+:8] = d[8*b+:8];
  endtask
  task automatic drv(logic iv, logic [13:0] ia, logic lv, logic [13:0] la, logic we, logic [31:0] wd, logic [3:0] wm);
    bus.ifu_req_valid = iv; bus.ifu_req_addr = ia;
    bus.lsu_req_valid = lv; bus.lsu_req_addr = la; bus.lsu_req_we = we;
    bus.lsu_req_wdata = wd; bus.lsu_req_wem = wm;
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  typedef struct {
    logic iv; logic [13:0] ia; logic lv; logic [13:0] la; logic we; logic [31:0] wd; logic [3:0] wm;
    logic eir, elr, ewe; logic [13:0] eaddr; logic eirv, elrv;
  } vec_t;
  vec_t tbl [7];
  logic iv, lv, lwe, gi_e, gl_e, pi, pl, prd;
  logic [13:0] ia, la, last;
  logic [31:0] wd, pd;
  logic [3:0] wm;
  int wins;
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    tbl[0] = '{0, 14'h00, 0, 14'h00, 0, 32'h0, 4'h0, 0, 0, 0, 14'h00, 0, 0};
    tbl[1] = '{1, 14'h10, 0, 14'h00, 0, 32'h0, 4'h0, 1, 0, 0, 14'h10, 0, 0};
    tbl[2] = '{0, 14'h00, 1, 14'h06, 0, 32'h0, 4'h0, 0, 1, 0, 14'h06, 1, 0};
    tbl[3] = '{0, 14'h00, 1, 14'h40, 1, 32'h1234_5678, 4'hC, 0, 1, 1, 14'h40, 0, 1};
    tbl[4] = '{0, 14'h00, 0, 14'h00, 0, 32'h0, 4'h0, 0, 0, 0, 14'h40, 0, 1};
    tbl[5] = '{1, 14'h05, 1, 14'h06, 0, 32'h0, 4'h0, 0, 1, 0, 14'h06, 0, 0};
    tbl[6] = '{1, 14'h05, 0, 14'h00, 0, 32'h0, 4'h0, 1, 0, 0, 14'h05, 0, 1};
    drv(0, 0, 0, 0, 0, 0, 0);
    mem_clr = 1;
    @(negedge clk);
    chk("reset ifu_rsp_valid", bus.ifu_rsp_valid, 0);
    chk("reset lsu_rsp_valid", bus.lsu_rsp_valid, 0);
    chk("reset ram_addr", bus.ram_addr, 0);
    tick;
    mem_clr = 0;
    rst = 0;
    for (int k = 0; k < 7; k++) begin
      drv(tbl[k].iv, tbl[k].ia, tbl[k].lv, tbl[k].la, tbl[k].we, tbl[k].wd, tbl[k].wm);
      @(negedge clk);
      chk($sformatf("vec%0d ifu_ready", k), bus.ifu_req_ready, tbl[k].eir);
      chk($sformatf("vec%0d lsu_ready", k), bus.lsu_req_ready, tbl[k].elr);
      chk($sformatf("vec%0d ram_we", k), bus.ram_we, tbl[k].ewe);
      chk($sformatf("vec%0d ram_addr", k), bus.ram_addr, tbl[k].eaddr);
      chk($sformatf("vec%0d ifu_rsp_valid", k), bus.ifu_rsp_valid, tbl[k].eirv);
      chk($sformatf("vec%0d lsu_rsp_valid", k), bus.lsu_rsp_valid, tbl[k].elrv);
      if (tbl[k].elr && tbl[k].we) apply_wr(tbl[k].la, tbl[k].wd, tbl[k].wm);
      tick;
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    tick;
    // back-to-back IFU fetches
    for (int k = 0; k < 5; k++) begin
      drv(k < 3, 14'(16 + k), 0, 0, 0, 0, 0);
      @(negedge clk);
      if (k < 3) chk("t1 ifu_ready", bus.ifu_req_ready, 1);
      chk("t1 ifu_rsp_valid", bus.ifu_rsp_valid, (k > 0 && k < 4));
      if (k > 0 && k < 4) chk("t1 ifu_rdata", bus.ifu_rsp_rdata, 32'hA0 + 32'(k - 1));
      tick;
    end
    // masked write then read-back on the next cycle
    drv(0, 0, 1, 14'h20, 1, 32'hDEAD_BEEF, 4'b0011);
    apply_wr(14'h20, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    chk("t2 ram_we", bus.ram_we, 1);
    chk("t2 ram_wem", bus.ram_wem, 4'b0011);
    chk("t2 ram_din", bus.ram_din, 32'hDEAD_BEEF);
    tick;
    drv(0, 0, 1, 14'h20, 0, 0, 0);
    @(negedge clk);
    chk("t2 write ack", bus.lsu_rsp_valid, 1);
    chk("t2 read ram_we", bus.ram_we, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2 read valid", bus.lsu_rsp_valid, 1);
    chk("t2 read data", bus.lsu_rsp_rdata, 32'h1122_BEEF);
    tick;
    // continuous contention: four LSU wins then one IFU grant
    for (int k = 0; k < 15; k++) begin
      drv(1, 14'h07, 1, 14'h08, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("t3 ifu_ready c%0d", k), bus.ifu_req_ready, (k % 5) == 4);
      chk($sformatf("t3 lsu_ready c%0d", k), bus.lsu_req_ready, (k % 5) != 4);
      tick;
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    tick;
    // simultaneous requests with room in the starvation budget
    drv(1, 14'h05, 1, 14'h06, 0, 0, 0);
    @(negedge clk);
    chk("t4 lsu_ready", bus.lsu_req_ready, 1);
    chk("t4 ifu_ready", bus.ifu_req_ready, 0);
    chk("t4 ram_addr lsu", bus.ram_addr, 14'h06);
    tick;
    drv(1, 14'h05, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4 lsu_rsp_valid", bus.lsu_rsp_valid, 1);
    chk("t4 lsu_rdata", bus.lsu_rsp_rdata, ref_mem[6]);
    chk("t4 ifu_ready", bus.ifu_req_ready, 1);
    chk("t4 ram_addr ifu", bus.ram_addr, 14'h05);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4 ifu_rsp_valid", bus.ifu_rsp_valid, 1);
    chk("t4 lsu_rsp_valid off", bus.lsu_rsp_valid, 0);
    chk("t4 ifu_rdata", bus.ifu_rsp_rdata, ref_mem[5]);
    tick;
    // reset right after an LSU read handshake; a write request during reset must not reach the RAM
    drv(0, 0, 1, 14'h09, 0, 0, 0);
    @(negedge clk);
    chk("t5 lsu_ready", bus.lsu_req_ready, 1);
    @(posedge clk);
    #1 rst = 1;
    drv(0, 0, 1, 14'h50, 1, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk("t5 rsp dropped", bus.lsu_rsp_valid, 0);
    chk("t5 no write in reset", bus.ram_we, 0);
    chk("t5 no grant in reset", bus.lsu_req_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5 post ifu_rsp_valid", bus.ifu_rsp_valid, 0);
    chk("t5 post lsu_rsp_valid", bus.lsu_rsp_valid, 0);
    chk("t5 post ram_we", bus.ram_we, 0);
    chk("t5 post ram_addr", bus.ram_addr, 0);
    tick;
    // idle after an access holds the address
    drv(0, 0, 1, 14'h33, 0, 0, 0);
    @(negedge clk);
    chk("t6 ram_addr", bus.ram_addr, 14'h33);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6 held addr", bus.ram_addr, 14'h33);
      chk("t6 ram_we", bus.ram_we, 0);
      chk("t6 lsu_rsp_valid", bus.lsu_rsp_valid, k == 0);
      chk("t6 ifu_rsp_valid", bus.ifu_rsp_valid, 0);
      tick;
    end
    // randomized traffic against a transaction model
    last = 14'h33; wins = 0; pi = 0; pl = 0; prd = 0; pd = 0; iv = 0; lv = 0;
    ia = 0; la = 0; lwe = 0; wd = 0; wm = 0;
    for (int n = 0; n < 800; n++) begin
      if (!iv) begin iv = $urandom_range(0, 2) != 0; ia = 14'($urandom_range(0, 255)); end
      if (!lv) begin
        lv = $urandom_range(0, 2) != 0; la = 14'($urandom_range(0, 255));
        lwe = 1'($urandom_range(0, 1)); wd = $urandom; wm = 4'($urandom_range(0, 15));
      end
      drv(iv, ia, lv, la, lwe, wd, wm);
      @(negedge clk);
      gl_e = lv && !(iv && wins == SM);
      gi_e = iv && !gl_e;
      chk("rnd ifu_ready", bus.ifu_req_ready, gi_e);
      chk("rnd lsu_ready", bus.lsu_req_ready, gl_e);
      chk("rnd ram_addr", bus.ram_addr, gl_e ? la : gi_e ? ia : last);
      chk("rnd ram_we", bus.ram_we, gl_e && lwe);
      chk("rnd ram_din", bus.ram_din, (gl_e && lwe) ? wd : 32'h0);
      chk("rnd ram_wem", bus.ram_wem, (gl_e && lwe) ? wm : 4'h0);
      chk("rnd ifu_rsp_valid", bus.ifu_rsp_valid, pi);
      chk("rnd lsu_rsp_valid", bus.lsu_rsp_valid, pl);
      if (pi) chk("rnd ifu_rdata", bus.ifu_rsp_rdata, pd);
      if (pl && prd) chk("rnd lsu_rdata", bus.lsu_rsp_rdata, pd);
      pi = gi_e; pl = gl_e; prd = gi_e || (gl_e && !lwe);
      if (gi_e) pd = ref_mem[ia[7:0]];
      else if (gl_e && !lwe) pd = ref_mem[la[7:0]];
      if (gl_e && lwe) apply_wr(la, wd, wm);
      wins = (!iv || gi_e) ? 0 : gl_e ? wins + 1 : wins;
      if (gi_e || gl_e) last = gl_e ? la : ia;
      if (gi_e) iv = 0;
      if (gl_e) lv = 0;
      tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
